// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared state encoding, accumulator sizing and saturation for the delay line engine
package fx_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WRITE,
    READ,
    OUT
  } state_e;

  // Dry sample plus NUM_TAPS attenuated taps, with one spare bit of headroom.
  function automatic int acc_width(input int data_w, input int num_taps);
    return data_w + $clog2(num_taps + 1) + 1;
  endfunction

  // Clamps v into the signed range of a w-bit word; the caller narrows the result to w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - single-port sample buffer, registered read, contents not reset
module sample_ram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/delay_line_engine.sv
// rtl/delay_line_engine.sv - circular-buffer multi-tap delay line with saturating mix and valid/ready output
module delay_line_engine
  import fx_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int ADDR_W    = 10,
  parameter int NUM_TAPS  = 2,
  parameter int TAP_SHIFT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DATA_W-1:0]          sample_in,
  input  logic [NUM_TAPS-1:0]        tap_en,
  input  logic [NUM_TAPS*ADDR_W-1:0] tap_delay,
  output logic [DATA_W-1:0]          sample_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       overrun
);

  localparam int ACC_W = acc_width(DATA_W, NUM_TAPS);
  localparam int TCW   = $clog2(NUM_TAPS + 1);

  state_e                   state_q;
  logic [ADDR_W-1:0]        clr_addr_q;
  logic [ADDR_W-1:0]        wr_ptr_q;
  logic [DATA_W-1:0]        sample_q;
  logic [NUM_TAPS-1:0]      en_q;
  logic [ADDR_W-1:0]        dly_q [NUM_TAPS];
  logic [TCW-1:0]           tap_cnt_q;
  logic [TCW-1:0]           rd_idx_q;
  logic                     rd_pend_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        sample_out_q;
  logic                     out_valid_q;
  logic                     busy_q;
  logic                     overrun_q;

  logic                     accept;
  logic                     ram_we;
  logic [ADDR_W-1:0]        ram_addr;
  logic [DATA_W-1:0]        ram_wdata;
  logic [DATA_W-1:0]        ram_rdata;
  logic [ADDR_W-1:0]        sel_dly;
  logic                     sel_en;
  logic signed [DATA_W-1:0] tap_shifted;
  logic signed [ACC_W-1:0]  tap_term;
  logic signed [ACC_W-1:0]  acc_d;
  logic [DATA_W-1:0]        sample_out_d;

  assign accept = start && (state_q == IDLE) && (!out_valid_q || out_ready);

  always_comb begin
    sel_dly = '0;
    sel_en  = 1'b0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (tap_cnt_q == TCW'(i)) sel_dly = dly_q[i];
      if (rd_idx_q == TCW'(i))  sel_en  = en_q[i];
    end
  end

  // RAM data lands one cycle after its address, so each tap is summed in the slot after its read.
  assign tap_shifted  = $signed(ram_rdata) >>> TAP_SHIFT;
  assign tap_term     = (rd_pend_q && sel_en) ? ACC_W'(tap_shifted) : '0;
  assign acc_d        = acc_q + tap_term;
  assign sample_out_d = DATA_W'(saturate(64'(acc_d), DATA_W));

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = wr_ptr_q;
    ram_wdata = sample_q;
    case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_addr_q;
        ram_wdata = '0;
      end
      WRITE:   ram_we = 1'b1;
      READ:    ram_addr = wr_ptr_q - sel_dly;
      default: ram_we = 1'b0;
    endcase
  end

  sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CLEAR;
      clr_addr_q   <= '0;
      wr_ptr_q     <= '0;
      sample_q     <= '0;
      en_q         <= '0;
      for (int i = 0; i < NUM_TAPS; i++) dly_q[i] <= '0;
      tap_cnt_q    <= '0;
      rd_idx_q     <= '0;
      rd_pend_q    <= 1'b0;
      acc_q        <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= start && !accept;
      rd_pend_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == '1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (accept) begin
            state_q  <= WRITE;
            busy_q   <= 1'b1;
            sample_q <= sample_in;
            en_q     <= tap_en;
            for (int i = 0; i < NUM_TAPS; i++) dly_q[i] <= tap_delay[i*ADDR_W +: ADDR_W];
            acc_q    <= ACC_W'($signed(sample_in));
          end
        end
        WRITE: begin
          state_q   <= READ;
          tap_cnt_q <= '0;
        end
        READ: begin
          acc_q     <= acc_d;
          rd_pend_q <= 1'b1;
          rd_idx_q  <= tap_cnt_q;
          tap_cnt_q <= tap_cnt_q + 1'b1;
          if (tap_cnt_q == TCW'(NUM_TAPS - 1)) begin
            state_q <= OUT;
          end
        end
        OUT: begin
          sample_out_q <= sample_out_d;
          out_valid_q  <= 1'b1;
          wr_ptr_q     <= wr_ptr_q + 1'b1;
          state_q      <= IDLE;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q <= CLEAR;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/delay_line_engine.md
Name: delay_line_engine

Overview:
- Parametrised successor to the fixed chorus/reverb read path.
- Stores each incoming ADC sample in a circular sample buffer.
- Reads NUM_TAPS delayed samples at runtime-programmable delays, sums the enabled taps (attenuated) with the dry sample, and saturates the result.
- Sits between the ADC SPI capture and the MCU SPI shift register. Presents each processed sample with a valid/ready handshake.

Parameters:
- DATA_W, 12, sample width (two's complement).
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples.
- NUM_TAPS, 2, number of delay taps.
- TAP_SHIFT, 1, arithmetic right shift applied to every tap before summing.

Ports:
- clk  in  1  sample-processing clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sample_in valid this cycle.
- sample_in  in  DATA_W  signed input sample.
- tap_en  in  NUM_TAPS  per-tap enable; sampled at start.
- tap_delay  in  NUM_TAPS*ADDR_W  tap i delay at [i*ADDR_W +: ADDR_W], in samples; sampled at start.
- sample_out  out  DATA_W  signed processed sample.
- out_valid  out  1  sample_out valid.
- out_ready  in  1  consumer accepts sample_out.
- busy  out  1  clearing or processing; start not accepted.
- overrun  out  1  one-cycle pulse: start dropped.

Behaviour:
- Reset (async assert, low):
  - state CLEAR, clr_addr=0, wr_ptr=0.
  - sample_out=0, out_valid=0, overrun=0, busy=1.
- CLEAR:
  - Writes 0 to addresses 0..DEPTH-1, one per cycle.
  - busy=1 for exactly DEPTH cycles after reset release, then IDLE.
- IDLE (busy=0): start accepted when not busy and (out_valid=0 or out_ready=1 that cycle).
- Cycle numbering: start accepted in cycle 0.
  - Cycle 1, WRITE: RAM[wr_ptr] <= sample_in; acc <= sign-extended sample_in; tap_en/tap_delay latched.
  - Cycles 2..NUM_TAPS+1, READ: issue tap k address = (wr_ptr - tap_delay[k]) mod DEPTH, k = 0..NUM_TAPS-1.
  - Delay 0 returns the sample just written.
  - RAM read latency is 1 cycle. Cycles 3..NUM_TAPS+2: acc += (tap data >>> TAP_SHIFT) if tap_en[k] latched, else += 0.
  - Disabled taps still occupy their slot, so latency is fixed.
  - After the last tap: wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
  - Cycle NUM_TAPS+3, OUT: sample_out <= saturate(acc); out_valid=1; busy=0.
- Accumulator: width ACC_W = DATA_W + clog2(NUM_TAPS+1) + 1, signed.
  - Saturation clamps to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
- Handshake:
  - out_valid and sample_out hold stable until an out_valid & out_ready cycle.
  - out_valid drops the next cycle unless a new result completes that same cycle.
- Overrun:
  - Triggered by start while busy, or start while out_valid=1 and out_ready=0.
  - overrun=1 the next cycle; sample discarded; no RAM write; wr_ptr and output unchanged.
- Simultaneous consume + start: both honoured; the new result overwrites sample_out at its OUT cycle.
- Reset mid-operation: pipeline is abandoned, outputs go to reset values immediately, and CLEAR reruns.
- tap_delay changes after start do not affect the sample in flight.

Decomposition:
- Package fx_pkg: state enum (CLEAR, IDLE, WRITE, READ, OUT); saturate function parametrised on widths; ACC_W helper.
- Sub-module sample_ram: synchronous single-port RAM, DATA_W x DEPTH, 1-cycle read latency, no reset on contents.
- Top FSM, tap counter, pointer and accumulator live in delay_line_engine.

Test Plan (DATA_W=12, ADDR_W=4, NUM_TAPS=2, TAP_SHIFT=1):
1. Release reset -> busy=1 for 16 cycles, then 0. start sample 100, taps disabled -> out_valid exactly 5 cycles later, sample_out=100.
2. tap0 enabled, delay 3; feed 400,0,0,0 with out_ready=1 -> outputs 400,0,0,200.
3. Both taps enabled, delay 0, sample 2000 -> sample_out=2047. Sample -2048 -> sample_out=-2048.
4. Wrap: tap0 delay 5; feed values 0..19 -> output for sample 18 is 18+(13>>>1)=24. Output for sample 3 is 3 (cleared RAM read).
5. Backpressure: out_ready=0, second start -> overrun pulse, sample_out unchanged. Next accepted sample lands at the un-incremented wr_ptr.
6. Assert reset during READ -> out_valid=0, sample_out=0 immediately; busy=1 for 16 cycles after release; prior samples read back as 0.
